// File: rtl/data_sram_if.sv
// ----------------------------------------------------------------------------
// data_sram_if
//   Request/response bundle of the data SRAM-like bus between the EXE/MEM
//   stages (master) and a data memory (slave).
//   Request  (master -> slave): data_sram_req, data_sram_wr, data_sram_size,
//                               data_sram_wstrb, data_sram_addr, data_sram_wdata
//   Response (slave -> master): data_sram_addr_ok, data_sram_data_ok,
//                               data_sram_rdata
// ----------------------------------------------------------------------------
interface data_sram_if;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_size,
             data_sram_wstrb, data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size,
             data_sram_wstrb, data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// ----------------------------------------------------------------------------
// data_sram_responder
//   Slave end of the data SRAM-like bus. Requests are accepted on
//   req & addr_ok, the backing RAM is written (per byte lane) or read at the
//   accept edge, and one data_ok pulse per request is returned in acceptance
//   order after LATENCY cycles. Up to DEPTH requests may be outstanding.
//
// Parameters
//   AW      word-address width, RAM holds 2**AW 32-bit words (addr[AW+1:2])
//   DEPTH   maximum outstanding requests (power of two, >= 2)
//   LATENCY cycles from accept to data_ok (>= 1)
//
// Ports
//   clk    clock, all state on the rising edge
//   reset  asynchronous active-high reset (RAM contents are kept)
//   bus    data_sram_if slave modport (req/wr/size/wstrb/addr/wdata in,
//          addr_ok/data_ok/rdata out)
//
// Configuration macro
//   RANDOM_DELAY_EN  when defined, a 16-bit LFSR randomly withholds addr_ok
//                    and adds 0..3 cycles of latency per request; responses
//                    stay strictly in order.
// ----------------------------------------------------------------------------
module data_sram_responder #(
   parameter int AW      = 10,
   parameter int DEPTH   = 4,
   parameter int LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   data_sram_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   // Countdown must hold up to LATENCY-1+3.
   localparam int CW = $clog2(LATENCY + 4);

   logic [PW:0]      count_reg;
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW-1:0]    fill_ptr_reg;
   logic             fill_valid_reg;
   logic [31:0]      ram_rdata_reg;
   logic [31:0]      mem        [2**AW];
   logic [31:0]      q_data_reg [DEPTH];

   logic [DEPTH-1:0] entry_valid;
   logic [DEPTH-1:0] entry_wr;
   logic [DEPTH-1:0] entry_zero;

   logic [AW-1:0]    word_idx;
   logic             gate_ok;
   logic [CW-1:0]    init_cnt;
   logic             addr_ok;
   logic             accept;
   logic             pop;
   logic             head_wr;
   logic [31:0]      head_data;
   logic             unused_bits;

   assign word_idx    = bus.data_sram_addr[AW+1:2];
   assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:AW+2],
                          bus.data_sram_addr[1:0]};

`ifdef RANDOM_DELAY_EN
   logic [15:0] lfsr_reg;

   // Fibonacci LFSR, taps 16/14/13/11, advances every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_reg <= 16'hACE1;
      end else begin
         lfsr_reg <= {lfsr_reg[14:0],
                      lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      end
   end

   assign gate_ok  = ~lfsr_reg[0];
   assign init_cnt = CW'(LATENCY - 1) + CW'(lfsr_reg[2:1]);
`else
   assign gate_ok  = 1'b1;
   assign init_cnt = CW'(LATENCY - 1);
`endif

   // addr_ok looks at the pre-pop count: a full queue never accepts, even on
   // the cycle its head is leaving.
   assign addr_ok = (count_reg != (PW+1)'(DEPTH)) && !reset && gate_ok;
   assign accept  = bus.data_sram_req && addr_ok;

   // Only the head may respond, so a slow head holds back younger entries.
   assign pop     = entry_valid[rd_ptr_reg] && entry_zero[rd_ptr_reg];
   assign head_wr = entry_wr[rd_ptr_reg];

   // Per-entry control: valid flag, read/write kind and latency countdown.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic          valid_reg;
      logic          is_wr_reg;
      logic [CW-1:0] cnt_reg;
      logic          push_here;
      logic          pop_here;

      assign push_here = accept && (wr_ptr_reg == PW'(gi));
      assign pop_here  = pop && (rd_ptr_reg == PW'(gi));

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            valid_reg <= 1'b0;
            is_wr_reg <= 1'b0;
            cnt_reg   <= '0;
         end else if (push_here) begin
            valid_reg <= 1'b1;
            is_wr_reg <= bus.data_sram_wr;
            cnt_reg   <= init_cnt;
         end else begin
            if (pop_here) begin
               valid_reg <= 1'b0;
            end
            if (valid_reg && (cnt_reg != '0)) begin
               cnt_reg <= cnt_reg - CW'(1);
            end
         end
      end

      assign entry_valid[gi] = valid_reg;
      assign entry_wr[gi]    = is_wr_reg;
      assign entry_zero[gi]  = (cnt_reg == '0);
   end

   // Pointers, occupancy and the pending read-data fill.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg      <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fill_valid_reg <= 1'b0;
         fill_ptr_reg   <= '0;
      end else begin
         if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({accept, pop})
            2'b10:   count_reg <= count_reg + (PW+1)'(1);
            2'b01:   count_reg <= count_reg - (PW+1)'(1);
            default: count_reg <= count_reg;
         endcase
         fill_valid_reg <= accept && !bus.data_sram_wr;
         fill_ptr_reg   <= wr_ptr_reg;
      end
   end

   // Backing RAM with a registered read port. The word read at the accept
   // edge lands in ram_rdata_reg and is copied into its queue slot one edge
   // later; until then the head mux below serves it straight from the port.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (bus.data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.data_sram_wstrb[b]) begin
                  mem[word_idx][b*8 +: 8] <= bus.data_sram_wdata[b*8 +: 8];
               end
            end
         end else begin
            ram_rdata_reg <= mem[word_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill_valid_reg) begin
         q_data_reg[fill_ptr_reg] <= ram_rdata_reg;
      end
   end

   assign head_data = (fill_valid_reg && (fill_ptr_reg == rd_ptr_reg))
                      ? ram_rdata_reg : q_data_reg[rd_ptr_reg];

   assign bus.data_sram_addr_ok = addr_ok;
   assign bus.data_sram_data_ok = pop && !reset;
   assign bus.data_sram_rdata   = (pop && !head_wr && !reset) ? head_data : 32'h0;
endmodule

// File: tb/tb_data_sram_responder.sv
// ----------------------------------------------------------------------------
// tb_data_sram_responder
//   Directed checks of data_sram_responder: a LATENCY=2 instance (dut2) for
//   write/read, byte strobes, back-to-back traffic, reset and a random
//   scoreboard run, and a LATENCY=8 instance (dut8) for the full-queue case.
//   Compile with RANDOM_DELAY_EN defined to exercise the random-delay build.
// ----------------------------------------------------------------------------
module tb_data_sram_responder;
   logic clk = 1'b0;
   logic reset;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   data_sram_if if2 ();
   data_sram_if if8 ();

   data_sram_responder #(.AW(10), .DEPTH(4), .LATENCY(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (if2)
   );

   data_sram_responder #(.AW(10), .DEPTH(4), .LATENCY(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (if8)
   );

`ifdef RANDOM_DELAY_EN
   localparam int   LMAX   = 5;
   localparam logic REL_OK = 1'b0;   // LFSR seed 16'hACE1 has bit 0 set
`else
   localparam int   LMAX   = 2;
   localparam logic REL_OK = 1'b1;
`endif

   typedef struct packed {
      logic        w;
      logic [31:0] d;
      int          t;
   } exp_t;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request on dut2, wait (bounded) for addr_ok, and return just
   // after the accepting edge with req dropped.
   task automatic issue(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      int n;
      n = 0;
      if2.data_sram_req   = 1'b1;
      if2.data_sram_wr    = w;
      if2.data_sram_size  = 2'd2;
      if2.data_sram_addr  = a;
      if2.data_sram_wdata = d;
      if2.data_sram_wstrb = s;
      while (!if2.data_sram_addr_ok && n < 40) begin
         step();
         n++;
      end
      check("issue_addr_ok", if2.data_sram_addr_ok, 1'b1);
      $display("txn req wr=%0b addr=%h wdata=%h wstrb=%h", w, a, d, s);
      step();
      if2.data_sram_req = 1'b0;
   endtask

   // Wait (bounded) for the next data_ok on dut2; lat=1 means data_ok was
   // already high right after the accepting edge. Returns after the pop edge.
   task automatic wait_resp(output logic [31:0] rd, output int lat);
      lat = 1;
      while (!if2.data_sram_data_ok && lat < 40) begin
         step();
         lat++;
      end
      check("resp_seen", if2.data_sram_data_ok, 1'b1);
      rd = if2.data_sram_rdata;
      $display("txn rsp rdata=%h lat=%0d", rd, lat);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          lat;
      logic [9:0]  ok_bits;
      logic [9:0]  dok_bits;
      int          resp8;
      int          stale;
      logic [31:0] model [8];
      exp_t        expq[$];
      exp_t        e;
      int          cyc;
      int          n_acc;
      int          guard;
      logic        pend;
      logic        pend_w;
      logic [2:0]  pend_i;
      logic [31:0] pend_d;
      logic [3:0]  pend_s;

      reset = 1'b1;
      if2.data_sram_req = 1'b0; if2.data_sram_wr = 1'b0; if2.data_sram_size = 2'd2;
      if2.data_sram_wstrb = 4'h0; if2.data_sram_addr = '0; if2.data_sram_wdata = '0;
      if8.data_sram_req = 1'b0; if8.data_sram_wr = 1'b0; if8.data_sram_size = 2'd2;
      if8.data_sram_wstrb = 4'h0; if8.data_sram_addr = '0; if8.data_sram_wdata = '0;

      // Reset state
      #2;
      check("rst_addr_ok", if2.data_sram_addr_ok, 1'b0);
      check("rst_data_ok", if2.data_sram_data_ok, 1'b0);
      check("rst_rdata", if2.data_sram_rdata, 32'h0);
      check("rst_addr_ok8", if8.data_sram_addr_ok, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("rel_addr_ok", if2.data_sram_addr_ok, REL_OK);

      // 1: full-word write then read back
      issue(1'b1, 32'h100, 32'h12345678, 4'hF);
      wait_resp(rd, lat);
      check("t1_wr_lat_ok", (lat >= 2 && lat <= LMAX), 1'b1);
      check("t1_wr_rdata", rd, 32'h0);
      check("t1_single", if2.data_sram_data_ok, 1'b0);
      issue(1'b0, 32'h100, 32'h0, 4'h0);
      wait_resp(rd, lat);
      check("t1_rd_lat_ok", (lat >= 2 && lat <= LMAX), 1'b1);
      check("t1_rd_rdata", rd, 32'h12345678);

      // 2: single-lane write, read with nonzero addr[1:0]
      issue(1'b1, 32'h100, 32'h0000AB00, 4'b0010);
      wait_resp(rd, lat);
      issue(1'b0, 32'h101, 32'h0, 4'h0);
      wait_resp(rd, lat);
      check("t2_rdata", rd, 32'h1234AB78);

      // 4: write then read of the same word in consecutive cycles
      issue(1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
`ifndef RANDOM_DELAY_EN
      check("t4_dok0", if2.data_sram_data_ok, 1'b1);
      check("t4_rdata0", if2.data_sram_rdata, 32'h0);
      step();
      check("t4_dok1", if2.data_sram_data_ok, 1'b1);
      check("t4_rdata1", if2.data_sram_rdata, 32'hDEADBEEF);
      step();
      check("t4_dok2", if2.data_sram_data_ok, 1'b0);
`else
      wait_resp(rd, lat);
      check("t4_wr_rdata", rd, 32'h0);
      wait_resp(rd, lat);
      check("t4_rd_rdata", rd, 32'hDEADBEEF);
`endif

      // wstrb = 0 leaves the word untouched
      issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
      wait_resp(rd, lat);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      wait_resp(rd, lat);
      check("strb0_rdata", rd, 32'hDEADBEEF);

      // 5: reset with reads outstanding
      issue(1'b0, 32'h100, 32'h0, 4'h0);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      issue(1'b0, 32'h100, 32'h0, 4'h0);
`ifndef RANDOM_DELAY_EN
      check("t5_pre_dok", if2.data_sram_data_ok, 1'b1);
`endif
      #3 reset = 1'b1;
      #1;
      check("t5_dok_rst", if2.data_sram_data_ok, 1'b0);
      check("t5_aok_rst", if2.data_sram_addr_ok, 1'b0);
      check("t5_rdata_rst", if2.data_sram_rdata, 32'h0);
      @(posedge clk);
      #3 reset = 1'b0;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (if2.data_sram_data_ok) stale++;
      end
      check("t5_no_stale", stale, 0);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      wait_resp(rd, lat);
      check("t5_reread0", rd, 32'hDEADBEEF);
      issue(1'b0, 32'h100, 32'h0, 4'h0);
      wait_resp(rd, lat);
      check("t5_reread1", rd, 32'h1234AB78);

`ifndef RANDOM_DELAY_EN
      // 3: LATENCY=8, req held high until the 5th accept
      if8.data_sram_req   = 1'b1;
      if8.data_sram_wr    = 1'b1;
      if8.data_sram_addr  = 32'h40;
      if8.data_sram_wdata = 32'h00005555;
      if8.data_sram_wstrb = 4'hF;
      for (int c = 0; c < 10; c++) begin
         ok_bits[c]  = if8.data_sram_addr_ok;
         dok_bits[c] = if8.data_sram_data_ok;
         step();
      end
      if8.data_sram_req = 1'b0;
      $display("txn dut8 addr_ok=%b data_ok=%b", ok_bits, dok_bits);
      check("t3_addr_ok_pattern", {22'h0, ok_bits}, 32'h20F);
      check("t3_data_ok_pattern", {22'h0, dok_bits}, 32'h300);
      resp8 = $countones(dok_bits);
      for (int c = 0; c < 20; c++) begin
         if (if8.data_sram_data_ok) resp8++;
         step();
      end
      check("t3_total_resp", resp8, 5);
`endif

      // 6: random reads/writes against a scoreboard
      for (int i = 0; i < 8; i++) begin
         pend_d = $urandom;
         issue(1'b1, 32'h200 + 32'(i * 4), pend_d, 4'hF);
         wait_resp(rd, lat);
         model[i] = pend_d;
      end
      cyc   = 0;
      n_acc = 0;
      guard = 0;
      pend  = 1'b0;
      while ((n_acc < 200 || expq.size() > 0) && guard < 5000) begin
         step();
         cyc++;
         guard++;
         if (pend) begin
            e.w = pend_w;
            e.t = cyc;
            if (pend_w) begin
               for (int b = 0; b < 4; b++) begin
                  if (pend_s[b]) model[pend_i][b*8 +: 8] = pend_d[b*8 +: 8];
               end
               e.d = 32'h0;
            end else begin
               e.d = model[pend_i];
            end
            expq.push_back(e);
            n_acc++;
            pend = 1'b0;
         end
         if (if2.data_sram_data_ok) begin
            if (expq.size() == 0) begin
               check("rnd_spurious_dok", if2.data_sram_data_ok, 1'b0);
            end else begin
               e   = expq.pop_front();
               lat = cyc - e.t + 1;
               $display("txn rnd rsp wr=%0b rdata=%h lat=%0d", e.w,
                        if2.data_sram_rdata, lat);
               check("rnd_rdata", if2.data_sram_rdata, e.d);
               check("rnd_lat_ok", (lat >= 2 && lat <= LMAX), 1'b1);
            end
         end
         if2.data_sram_req = 1'b0;
         if (n_acc < 200 && $urandom_range(3) != 0) begin
            pend_w = 1'($urandom_range(1));
            pend_i = 3'($urandom_range(7));
            pend_d = $urandom;
            pend_s = 4'($urandom_range(15));
            if2.data_sram_req   = 1'b1;
            if2.data_sram_wr    = pend_w;
            if2.data_sram_addr  = 32'h200 + {27'h0, pend_i, 2'b00};
            if2.data_sram_wdata = pend_d;
            if2.data_sram_wstrb = pend_s;
            pend = if2.data_sram_addr_ok;
         end
      end
      check("rnd_drained", expq.size(), 0);
      check("rnd_accepts", n_acc, 200);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
